alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Controller that owns the shared 32-bit ALU (the array of bit-slice ALUs with sel/invert/cin control) and sequences it for the execute stage.
It accepts one operation at a time over a valid/ready request channel and drives the ALU control and operand lines. Single-pass ops (add/sub/and/or/slt) complete in one cycle. MULTU is run as a 32-iteration shift-add loop on the ALU adder into HI/LO registers. Results return over a valid/ready response channel.

Parameters:
WIDTH, 32, datapath width; also the MULTU iteration count.
CNT_W, 6, width of the iteration counter (must hold WIDTH).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_funct  in  6  MIPS funct code
req_a  in  WIDTH  operand A (rs)
req_b  in  WIDTH  operand B (rt)
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b, before inversion
alu_sel  out  3  ALU select: 010 add, 110 sub, 000 and, 001 or, 111 slt
alu_invert  out  1  ALU b-invert
alu_cin  out  1  carry-in to bit 0
alu_result  in  WIDTH  ALU sum output
alu_cout  in  1  ALU carry-out of MSB
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  WIDTH  result word
rsp_err  out  1  unsupported funct flag, qualified by rsp_valid
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, hi=0, lo=0, counter=0, alu_sel=000, alu_invert=0, alu_cin=0, alu_a=0, alu_b=0.
- Reset mid-operation aborts any op. No response is produced, and HI/LO are cleared.
- States: IDLE, EXEC, MUL, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid&req_ready, latch funct/a/b.
  - funct 0x19 goes to MUL with hi=0, lo=req_b, multiplicand=req_a, counter=0.
  - Any other funct goes to EXEC.
- EXEC, one cycle. ALU is driven combinationally from the latched operands.
  - 0x20 add: sel=010, inv=0, cin=0.
  - 0x22 sub: sel=110, inv=1, cin=1.
  - 0x24 and: sel=000.
  - 0x25 or: sel=001.
  - 0x2A slt: sel=111, inv=1, cin=1.
  - For these five, rsp_data<=alu_result at the end of EXEC.
  - 0x10 mfhi: rsp_data<=hi. 0x12 mflo: rsp_data<=lo. Neither uses the ALU; drive sel=000.
  - Any other funct: rsp_data<=0, rsp_err<=1. HI/LO are unchanged.
  - EXEC always goes to RESP. Latency from accepting edge to rsp_valid is 1 cycle.
- MUL iteration, each cycle:
  - alu_a=hi, alu_b=(lo[0] ? multiplicand : 0), sel=010, inv=0, cin=0.
  - At the edge: hi<={alu_cout, alu_result[WIDTH-1:1]}, lo<={alu_result[0], lo[WIDTH-1:1]}, counter++.
  - After the WIDTH-th iteration (counter==WIDTH-1 at the edge), go to RESP with rsp_data<=final lo value and rsp_err<=0.
  - Latency is WIDTH cycles. The product is unsigned and 2*WIDTH bits in {hi,lo}.
- RESP: rsp_valid=1, with rsp_data/rsp_err held stable.
  - On rsp_ready, go to IDLE and clear rsp_valid and rsp_err the next cycle.
  - A new request is not accepted in the same cycle as the response handshake (no bypass). Back-to-back throughput for single ops is 1 op per 3 cycles.
- Outside EXEC/MUL: alu_sel=000, inv=0, cin=0, alu_a=alu_b=0.
- Add/sub overflow is not detected; results wrap modulo 2^WIDTH.
- hi/lo are modified only by MULTU.

Test Plan:
1. Reset, then add: req a=5, b=7, funct 0x20 -> during EXEC sel=010, inv=0, cin=0; rsp_valid 1 cycle after accept; rsp_data=12, rsp_err=0.
2. slt signed: a=0xFFFFFFFD, b=2, funct 0x2A -> sel=111, inv=1, cin=1 in EXEC; rsp_data=1. Swapped operands -> rsp_data=0.
3. MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> req_ready low for 32 MUL cycles; rsp_valid 32 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001, rsp_data=0x00000001. Then mfhi returns 0xFFFFFFFE.
4. Backpressure: sub a=3, b=10 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_data=0xFFFFFFF9 stable, req_ready=0. Response completes on the first cycle with rsp_ready=1.
5. Unsupported funct 0x03 -> rsp_err=1, rsp_data=0, hi/lo unchanged.
6. Reset mid-MULTU (rst pulse at iteration 10) -> all outputs at reset values immediately, no response. A following add 1+1 returns 2 normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: owns the shared bit-slice ALU, runs single-pass ops in one
// cycle and MULTU as a WIDTH-iteration shift-add loop into HI/LO.
module alu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_invert,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t           state_q, state_n;
  logic [5:0]       funct_q, funct_n;
  logic [WIDTH-1:0] a_q, a_n;       // operand A; multiplicand during MUL
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] data_n;
  logic             err_n;

  // Next-state, datapath next values and combinational ALU control
  always_comb begin
    state_n    = state_q;
    funct_n    = funct_q;
    a_n        = a_q;
    b_n        = b_q;
    hi_n       = hi;
    lo_n       = lo;
    cnt_n      = cnt_q;
    data_n     = rsp_data;
    err_n      = rsp_err;
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = SEL_AND;
    alu_invert = 1'b0;
    alu_cin    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          funct_n = req_funct;
          a_n     = req_a;
          b_n     = req_b;
          if (req_funct == F_MULTU) begin
            hi_n    = '0;
            lo_n    = req_b;
            cnt_n   = '0;
            state_n = MUL;
          end else begin
            state_n = EXEC;
          end
        end
      end

      EXEC: begin
        err_n = 1'b0;
        case (funct_q)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            alu_a  = a_q;
            alu_b  = b_q;
            data_n = alu_result;
            case (funct_q)
              F_ADD: alu_sel = SEL_ADD;
              F_SUB: begin
                alu_sel    = SEL_SUB;
                alu_invert = 1'b1;
                alu_cin    = 1'b1;
              end
              F_OR:  alu_sel = SEL_OR;
              F_SLT: begin
                alu_sel    = SEL_SLT;
                alu_invert = 1'b1;
                alu_cin    = 1'b1;
              end
              default: alu_sel = SEL_AND;
            endcase
          end
          F_MFHI: data_n = hi;
          F_MFLO: data_n = lo;
          default: begin
            data_n = '0;
            err_n  = 1'b1;
          end
        endcase
        state_n = RESP;
      end

      MUL: begin
        // Add the multiplicand into HI when the current multiplier bit is set,
        // then shift {carry, HI, LO} right by one.
        alu_a   = hi;
        alu_b   = lo[0] ? a_q : '0;
        alu_sel = SEL_ADD;
        hi_n    = {alu_cout, alu_result[WIDTH-1:1]};
        lo_n    = {alu_result[0], lo[WIDTH-1:1]};
        cnt_n   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          data_n  = lo_n;
          err_n   = 1'b0;
          state_n = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; handshake flags registered from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      funct_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt_q     <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      funct_q   <= funct_n;
      a_q       <= a_n;
      b_q       <= b_n;
      hi        <= hi_n;
      lo        <= lo_n;
      cnt_q     <= cnt_n;
      rsp_data  <= data_n;
      rsp_err   <= err_n;
      req_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural bit-slice ALU plus a table of
// directed operations with hand-computed results, and a mid-MULTU reset.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_invert, alu_cin, alu_cout;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_invert(alu_invert), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .hi(hi), .lo(lo)
  );

  // Shared ALU: b-invert, ripple adder with cin, slt from the sum sign bit
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    bb       = alu_invert ? ~alu_b : alu_b;
    sum      = {1'b0, alu_a} + {1'b0, bb} + 33'(alu_cin);
    alu_cout = sum[32];
    case (alu_sel)
      3'b000:         alu_result = alu_a & bb;
      3'b001:         alu_result = alu_a | bb;
      3'b010, 3'b110: alu_result = sum[31:0];
      3'b111:         alu_result = {31'b0, sum[31]};
      default:        alu_result = 32'h0;
    endcase
  end

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a, b, data;
    logic        err;
    logic [2:0]  sel;
    logic        inv, cin, chk_ab;
    logic [31:0] ea, eb;
    int          lat;
    logic [31:0] ehi, elo;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] f, logic [31:0] a, logic [31:0] b,
                              logic [31:0] d, logic e, logic [2:0] s, logic iv,
                              logic ci, logic cab, logic [31:0] ea, logic [31:0] eb,
                              int lat, logic [31:0] h, logic [31:0] l, int hold);
    vec_t v;
    v.funct = f; v.a = a; v.b = b; v.data = d; v.err = e; v.sel = s;
    v.inv = iv; v.cin = ci; v.chk_ab = cab; v.ea = ea; v.eb = eb;
    v.lat = lat; v.ehi = h; v.elo = l; v.hold = hold;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Waits (bounded) for req_ready at a falling edge, then presents one request
  task automatic send_req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready before request", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_funct = 6'h0;
    req_a     = 32'h0;
    req_b     = 32'h0;
  endtask

  // Runs one operation end to end; entered and left at a falling edge
  task automatic run_op(input vec_t v);
    int lat;
    logic [31:0] held;
    send_req(v.funct, v.a, v.b);
    @(negedge clk);
    check("alu_sel first cycle", 32'(alu_sel), 32'(v.sel));
    check("alu_invert first cycle", 32'(alu_invert), 32'(v.inv));
    check("alu_cin first cycle", 32'(alu_cin), 32'(v.cin));
    if (v.chk_ab) begin
      check("alu_a first cycle", alu_a, v.ea);
      check("alu_b first cycle", alu_b, v.eb);
    end
    check("req_ready busy", 32'(req_ready), 32'd0);
    check("rsp_valid early", 32'(rsp_valid), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 100);
    check("latency", 32'(lat), 32'(v.lat));
    check("rsp_data", rsp_data, v.data);
    check("rsp_err", 32'(rsp_err), 32'(v.err));
    check("hi", hi, v.ehi);
    check("lo", lo, v.elo);
    check("alu_sel idle in RESP", 32'(alu_sel), 32'd0);
    check("alu_a idle in RESP", alu_a, 32'd0);
    held = rsp_data;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("rsp_valid held", 32'(rsp_valid), 32'd1);
      check("rsp_data held", rsp_data, held);
      check("req_ready held", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid after handshake", 32'(rsp_valid), 32'd0);
    check("rsp_err after handshake", 32'(rsp_err), 32'd0);
    check("req_ready after handshake", 32'(req_ready), 32'd1);
  endtask

  initial begin
    //            funct  a             b             data          err sel     inv cin ab  ea            eb            lat hi            lo            hold
    vecs.push_back(mk(6'h20, 32'd5,        32'd7,        32'd12,       0, 3'b010, 0, 0, 1, 32'd5,        32'd7,        1,  32'h0,        32'h0,        0));
    vecs.push_back(mk(6'h2A, 32'hFFFFFFFD, 32'd2,        32'd1,        0, 3'b111, 1, 1, 1, 32'hFFFFFFFD, 32'd2,        1,  32'h0,        32'h0,        0));
    vecs.push_back(mk(6'h2A, 32'd2,        32'hFFFFFFFD, 32'd0,        0, 3'b111, 1, 1, 1, 32'd2,        32'hFFFFFFFD, 1,  32'h0,        32'h0,        0));
    vecs.push_back(mk(6'h24, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 0, 3'b000, 0, 0, 1, 32'hF0F01234, 32'h0FF0FF00, 1,  32'h0,        32'h0,        0));
    vecs.push_back(mk(6'h25, 32'hF0000001, 32'h0000F000, 32'hF000F001, 0, 3'b001, 0, 0, 1, 32'hF0000001, 32'h0000F000, 1,  32'h0,        32'h0,        0));
    vecs.push_back(mk(6'h22, 32'd3,        32'd10,       32'hFFFFFFF9, 0, 3'b110, 1, 1, 1, 32'd3,        32'd10,       1,  32'h0,        32'h0,        5));
    vecs.push_back(mk(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 3'b010, 0, 0, 1, 32'h0,        32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001, 0));
    vecs.push_back(mk(6'h10, 32'h0,        32'h0,        32'hFFFFFFFE, 0, 3'b000, 0, 0, 0, 32'h0,        32'h0,        1,  32'hFFFFFFFE, 32'h00000001, 0));
    vecs.push_back(mk(6'h12, 32'h0,        32'h0,        32'h00000001, 0, 3'b000, 0, 0, 0, 32'h0,        32'h0,        1,  32'hFFFFFFFE, 32'h00000001, 0));
    vecs.push_back(mk(6'h03, 32'h1234,     32'h5678,     32'h0,        1, 3'b000, 0, 0, 0, 32'h0,        32'h0,        1,  32'hFFFFFFFE, 32'h00000001, 0));
    vecs.push_back(mk(6'h20, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 3'b010, 0, 0, 1, 32'hFFFFFFFF, 32'd1,        1,  32'hFFFFFFFE, 32'h00000001, 0));
    vecs.push_back(mk(6'h19, 32'h12345678, 32'h00000100, 32'h34567800, 0, 3'b010, 0, 0, 1, 32'h0,        32'h0,        32, 32'h00000012, 32'h34567800, 0));
    vecs.push_back(mk(6'h22, 32'd100,      32'd1,        32'd99,       0, 3'b110, 1, 1, 1, 32'd100,      32'd1,        1,  32'h00000012, 32'h34567800, 2));
    vecs.push_back(mk(6'h19, 32'd3,        32'd5,        32'd15,       0, 3'b010, 0, 0, 1, 32'h0,        32'd3,        32, 32'h0,        32'd15,       0));
    vecs.push_back(mk(6'h10, 32'h0,        32'h0,        32'h0,        0, 3'b000, 0, 0, 0, 32'h0,        32'h0,        1,  32'h0,        32'd15,       0));
    vecs.push_back(mk(6'h12, 32'h0,        32'h0,        32'd15,       0, 3'b000, 0, 0, 0, 32'h0,        32'h0,        1,  32'h0,        32'd15,       0));

    rst       = 1'b1;
    req_valid = 1'b0;
    req_funct = 6'h0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset alu_sel", 32'(alu_sel), 32'd0);
    check("reset alu_ctl", 32'({alu_invert, alu_cin}), 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset pulse during the tenth MULTU iteration aborts the operation
    send_req(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid-mul busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort rsp_data", rsp_data, 32'd0);
    check("abort alu_sel", 32'(alu_sel), 32'd0);
    check("abort alu_a", alu_a, 32'd0);
    check("abort alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("no response after abort", 32'(rsp_valid), 32'd0);
    run_op(mk(6'h20, 32'd1, 32'd1, 32'd2, 0, 3'b010, 0, 0, 1, 32'd1, 32'd1, 1, 32'h0, 32'h0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
